uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of an 8-bit LSB-first serializer.
// Optional even parity bit is compiled in with `define UART_TX_PARITY_EN (8E1 instead of 8N1).
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic       o_serial_tx,
  output logic       o_busy
);

  localparam int SYMBOL_CYCLES = CLOCK_FREQ / BAUD_RATE;
  localparam int BAUD_W        = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam int CNT_W         = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         head;
  logic               push;
  logic               pop;
  logic               baud_end;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_data_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign push         = i_data_valid && o_data_ready;
  assign head         = mem_q[rd_ptr_q];
  assign baud_end     = (baud_q == BAUD_W'(SYMBOL_CYCLES - 1));
  assign o_serial_tx  = tx_q;
  assign o_busy       = (state_q != IDLE) || (count_q != '0);

  // FIFO bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop      = 1'b1;
          shift_d  = head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes leave without an idle gap.
          if (count_q != '0) begin
            pop      = 1'b1;
            shift_d  = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

    // Line level follows the state being entered, so it is registered glitch-free.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo at 10 clocks per bit; a line monitor checks every frame cycle-by-cycle.
module tb_uart_tx_fifo;

  localparam int SYM = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * SYM;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_data_valid = 1'b0;
  logic       o_data_ready;
  logic       o_serial_tx;
  logic       o_busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int push_edge = 0;
  logic [7:0] expq [$];

  uart_tx_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .o_serial_tx(o_serial_tx), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Caller sits at a negedge; returns at the following negedge with push_edge = accepting edge.
  task automatic drive_push(input logic [7:0] b, input bit exp_acc, input string nm);
    i_data = b;
    i_data_valid = 1'b1;
    check(nm, o_data_ready, exp_acc);
    if (exp_acc) expq.push_back(b);
    @(posedge i_clk);
    #1;
    push_edge = cyc;
    @(negedge i_clk);
    i_data_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge i_clk);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check(nm, o_busy, 1'b0);
    repeat (3) @(negedge i_clk);
  endtask

  // Line monitor: pops the expected byte at each start bit and checks every cycle of the frame.
  initial begin
    logic [7:0] eb;
    logic [7:0] rx;
    int bad;
    bit aborted;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_serial_tx === 1'b0) begin
        if (expq.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          eb = 8'h00;
        end else begin
          eb = expq.pop_front();
        end
        bad = 0;
        aborted = 1'b0;
        rx = 8'h00;
        for (int s = 0; s < FRAME_CYC; s++) begin
          if (s > 0) @(negedge i_clk);
          if (!i_rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (o_serial_tx !== exp_bit(eb, s / SYM)) bad++;
          if ((s % SYM) == SYM / 2 && s / SYM >= 1 && s / SYM <= 8) rx[s/SYM-1] = o_serial_tx;
        end
        if (!aborted) begin
          check("frame_bad_cycles", bad, 0);
          check("frame_byte", rx, eb);
        end
      end
    end
  end

  initial begin
    int n0;
    int lows;
    int busys;
    repeat (3) @(negedge i_clk);
    check("rst_ready", o_data_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_tx", o_serial_tx, 1'b1);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Single byte 0xA5: start bit visible two edges after the push, frame length exact.
    drive_push(8'hA5, 1'b1, "a5_ready");
    n0 = push_edge;
    check("a5_tx_before_start", o_serial_tx, 1'b1);
    @(negedge i_clk);
    check("a5_start_low", o_serial_tx, 1'b0);
    check("a5_busy", o_busy, 1'b1);
    wait_cyc(n0 + FRAME_CYC);
    check("a5_stop_high", o_serial_tx, 1'b1);
    check("a5_busy_in_stop", o_busy, 1'b1);
    @(negedge i_clk);
    check("a5_busy_after", o_busy, 1'b0);
    wait_idle("a5_idle", 50);

    // Three back-to-back bytes form contiguous frames.
    drive_push(8'h01, 1'b1, "b2b_ready0");
    n0 = push_edge;
    drive_push(8'h02, 1'b1, "b2b_ready1");
    drive_push(8'h03, 1'b1, "b2b_ready2");
    wait_cyc(n0 + FRAME_CYC);
    check("b2b_stop1", o_serial_tx, 1'b1);
    @(negedge i_clk);
    check("b2b_start2_no_gap", o_serial_tx, 1'b0);
    wait_cyc(n0 + 3 * FRAME_CYC);
    check("b2b_busy_end", o_busy, 1'b1);
    @(negedge i_clk);
    check("b2b_idle_at_3frames", o_busy, 1'b0);
    wait_idle("b2b_idle", 50);

    // Fill: one byte in flight plus four stored, sixth dropped.
    drive_push(8'h11, 1'b1, "fill_ready0");
    drive_push(8'h22, 1'b1, "fill_ready1");
    drive_push(8'h33, 1'b1, "fill_ready2");
    drive_push(8'h44, 1'b1, "fill_ready3");
    drive_push(8'h55, 1'b1, "fill_ready4");
    drive_push(8'h66, 1'b0, "fill_full_ready");
    check("fill_ready_stays_low", o_data_ready, 1'b0);
    wait_idle("fill_idle", 6 * FRAME_CYC + 50);

`ifdef UART_TX_PARITY_EN
    drive_push(8'h07, 1'b1, "par07_ready");
    n0 = push_edge;
    wait_cyc(n0 + 1 + 9 * SYM + SYM / 2);
    check("par07_parity_bit", o_serial_tx, 1'b1);
    wait_idle("par07_idle", FRAME_CYC + 50);
    drive_push(8'h03, 1'b1, "par03_ready");
    n0 = push_edge;
    wait_cyc(n0 + 1 + 9 * SYM + SYM / 2);
    check("par03_parity_bit", o_serial_tx, 1'b0);
    wait_idle("par03_idle", FRAME_CYC + 50);
`endif

    // Push on the very edge that pops the last queued byte at the end of a stop bit.
    drive_push(8'h5A, 1'b1, "same_ready_a");
    n0 = push_edge;
    wait_cyc(n0 + 20);
    drive_push(8'hB4, 1'b1, "same_ready_b");
    wait_cyc(n0 + FRAME_CYC);
    drive_push(8'hC3, 1'b1, "same_ready_c");
    check("same_next_start", o_serial_tx, 1'b0);
    drive_push(8'hD2, 1'b1, "same_ready_d");
    drive_push(8'hE1, 1'b1, "same_ready_e");
    drive_push(8'hF0, 1'b1, "same_ready_f");
    drive_push(8'h99, 1'b0, "same_full_ready");
    wait_idle("same_idle", 6 * FRAME_CYC + 50);

    // Reset in the middle of the data bits of 0x3C.
    drive_push(8'h3C, 1'b1, "rstmid_ready");
    n0 = push_edge;
    wait_cyc(n0 + 35);
    i_rst_n = 1'b0;
    #1;
    check("rstmid_tx", o_serial_tx, 1'b1);
    check("rstmid_busy", o_busy, 1'b0);
    check("rstmid_ready_after", o_data_ready, 1'b1);
    expq.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    lows = 0;
    busys = 0;
    repeat (2 * FRAME_CYC) begin
      @(negedge i_clk);
      if (o_serial_tx !== 1'b1) lows++;
      if (o_busy !== 1'b0) busys++;
    end
    check("rstmid_no_frame", lows, 0);
    check("rstmid_no_busy", busys, 0);

    check("scoreboard_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
